jtcop_obj_dma: RTL



---
 rtl/jtcop_obj_dma.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/jtcop_obj_dma.sv
// ============================================================================
// jtcop_obj_dma
// ----------------------------------------------------------------------------
// Object-table DMA with a double-buffered table for the sprite draw engine.
// A rising edge on dma_req copies the whole CPU object RAM into the back bank.
// The finished copy is marked pending. At the next VBLANK start the banks swap,
// so the draw engine only ever reads a complete, stable table.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   dma_req   in   CPU DMA register strobe (level; rising edge starts a copy)
//   LVBL      in   vertical blank, active low (falling edge = VBLANK start)
//   obj_addr  out  read address into the CPU object RAM (second port)
//   obj_dout  in   object RAM data, valid one clock after obj_addr
//   tbl_addr  in   draw-engine read address
//   tbl_dout  out  registered front-bank data, one clock after tbl_addr
//   dma_busy  out  high while a copy is in progress
//   bank      out  current front bank
// ============================================================================
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dma_req,
    input  logic          LVBL,
    output logic [AW-1:0] obj_addr,
    input  logic [DW-1:0] obj_dout,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] tbl_dout,
    output logic          dma_busy,
    output logic          bank
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COPY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    r_state;
    logic          r_dma_req_l;
    logic          r_lvbl_l;
    logic [AW-1:0] r_obj_addr;
    logic [AW-1:0] r_wr_addr_d;
    logic          r_wr_en_d;
    logic          r_busy;
    logic          r_pending;
    logic          r_restart;
    logic          r_bank;
    logic [DW-1:0] r_tbl_dout;

    logic [DW-1:0] r_mem0 [2**AW];
    logic [DW-1:0] r_mem1 [2**AW];

    logic w_trig;
    logic w_vbl_start;
    logic w_swap;
    logic w_last;

    assign w_trig      = dma_req & ~r_dma_req_l;
    assign w_vbl_start = r_lvbl_l & ~LVBL;
    // A copy still running blocks the swap; the check waits for the next VBLANK.
    assign w_swap      = w_vbl_start & r_pending & ~r_busy;
    assign w_last      = (r_obj_addr == {AW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dma_req_l <= 1'b0;
            r_lvbl_l    <= 1'b1;
            r_obj_addr  <= '0;
            r_wr_addr_d <= '0;
            r_wr_en_d   <= 1'b0;
            r_busy      <= 1'b0;
            r_pending   <= 1'b0;
            r_restart   <= 1'b0;
            r_bank      <= 1'b0;
        end else begin
            r_dma_req_l <= dma_req;
            r_lvbl_l    <= LVBL;
            r_wr_en_d   <= 1'b0;

            // The swap is evaluated before the FSM so that a trigger in the
            // same clock targets the new back bank and clears pending again.
            if (w_swap) begin
                r_bank    <= ~r_bank;
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_state    <= ST_COPY;
                        r_obj_addr <= '0;
                        r_busy     <= 1'b1;
                        r_pending  <= 1'b0;
                        r_restart  <= 1'b0;
                    end
                end
                ST_COPY: begin
                    // Address wraps to zero after the last word and stays there.
                    r_obj_addr  <= r_obj_addr + 1'b1;
                    r_wr_addr_d <= r_obj_addr;
                    r_wr_en_d   <= 1'b1;
                    if (w_last) r_state <= ST_FLUSH;
                    if (w_trig) r_restart <= 1'b1;
                end
                ST_FLUSH: begin
                    // A trigger arriving in this very clock also counts as a restart.
                    if (r_restart || w_trig) begin
                        r_restart  <= 1'b0;
                        r_state    <= ST_COPY;
                        r_obj_addr <= '0;
                    end else begin
                        r_busy    <= 1'b0;
                        r_pending <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Back bank is ~bank; the write lands one clock after the address issue,
    // when the object RAM data for that address is on obj_dout.
    always_ff @(posedge clk) begin
        if (r_wr_en_d) begin
            if (r_bank) r_mem0[r_wr_addr_d] <= obj_dout;
            else        r_mem1[r_wr_addr_d] <= obj_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tbl_dout <= '0;
        else        r_tbl_dout <= r_bank ? r_mem1[tbl_addr] : r_mem0[tbl_addr];
    end

    assign obj_addr = r_obj_addr;
    assign tbl_dout = r_tbl_dout;
    assign dma_busy = r_busy;
    assign bank     = r_bank;

endmodule
